cpu_datapath: RTL and testbench

//  Single-bus 32-bit CPU datapath: register file, PC, IR, Y, 64-bit Z, HI/LO, MAR, MDR, ALU and bus mux.

---
 rtl/datapath_pkg.sv | 41 ++++
 rtl/cpu_datapath_units.sv | 91 +++++++++
 rtl/cpu_datapath.sv | 141 ++++++++++++++
 tb/tb_cpu_datapath.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared widths, ALU opcodes and bus-encoder source indices for cpu_datapath.
package datapath_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned ZW    = 2 * WIDTH;
  localparam int unsigned OPW   = 5;
  localparam int unsigned SELW  = 5;
  localparam int unsigned CIMMW = 19;

  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_ROR  = 5'b00111;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01000;
  localparam logic [OPW-1:0] OP_SHR  = 5'b01001;
  localparam logic [OPW-1:0] OP_SHRA = 5'b01010;
  localparam logic [OPW-1:0] OP_SHL  = 5'b01011;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPW-1:0] OP_NOT  = 5'b10010;

  localparam logic [SELW-1:0] ENC_R3     = 5'd3;
  localparam logic [SELW-1:0] ENC_R4     = 5'd4;
  localparam logic [SELW-1:0] ENC_R7     = 5'd7;
  localparam logic [SELW-1:0] ENC_HI     = 5'd16;
  localparam logic [SELW-1:0] ENC_LO     = 5'd17;
  localparam logic [SELW-1:0] ENC_ZHIGH  = 5'd18;
  localparam logic [SELW-1:0] ENC_ZLOW   = 5'd19;
  localparam logic [SELW-1:0] ENC_PC     = 5'd20;
  localparam logic [SELW-1:0] ENC_MDR    = 5'd21;
  localparam logic [SELW-1:0] ENC_INPORT = 5'd22;
  localparam logic [SELW-1:0] ENC_C      = 5'd23;

  // Immediate field of IR, sign-extended to bus width.
  function automatic logic [WIDTH-1:0] sign_ext_c(input logic [CIMMW-1:0] imm);
    return {{(WIDTH - CIMMW){imm[CIMMW-1]}}, imm};
  endfunction

endpackage

// File: rtl/cpu_datapath_units.sv
// Datapath leaf units: priority bus encoder, MDR register and 64-bit ALU.
// ALU MUL/DIV are built only when DATAPATH_MULDIV_EN is defined.
module bus_encoder (
  input  logic [31:0] encoderInput,
  output logic [4:0]  encoderOutput
);

  // Lowest set bit wins.
  always_comb begin
    encoderOutput = '0;
    for (int i = 31; i >= 0; i--) begin
      if (encoderInput[i]) encoderOutput = 5'(i);
    end
  end

endmodule

module mdr_unit
  import datapath_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             MDRin,
  input  logic             Read,
  input  logic [WIDTH-1:0] bus,
  input  logic [WIDTH-1:0] Mdatain,
  output logic [WIDTH-1:0] MDRout
);

  always_ff @(posedge clk) begin
    if (reset) begin
      MDRout <= '0;
    end else if (MDRin) begin
      MDRout <= Read ? Mdatain : bus;
    end
  end

endmodule

module alu
  import datapath_pkg::*;
(
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OPW-1:0]   operation,
  input  logic             IncPC,
  output logic [ZW-1:0]    result
);

  logic [4:0] sh;
  assign sh = B[4:0];

`ifdef DATAPATH_MULDIV_EN
  logic [ZW-1:0]    prod;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign prod = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
  assign quot = (B == '0) ? '0 : WIDTH'($signed(A) / $signed(B));
  assign rem  = (B == '0) ? '0 : WIDTH'($signed(A) % $signed(B));
`endif

  always_comb begin
    result = '0;
    if (IncPC) begin
      result = {{WIDTH{1'b0}}, B + WIDTH'(1)};
    end else begin
      case (operation)
        OP_ADD:  result = {{WIDTH{1'b0}}, A + B};
        OP_SUB:  result = {{WIDTH{1'b0}}, A - B};
        OP_AND:  result = {{WIDTH{1'b0}}, A & B};
        OP_OR:   result = {{WIDTH{1'b0}}, A | B};
        // A shift by the full width yields zero, so sh == 0 degenerates to A.
        OP_ROR:  result = {{WIDTH{1'b0}}, (A >> sh) | (A << (6'd32 - 6'(sh)))};
        OP_ROL:  result = {{WIDTH{1'b0}}, (A << sh) | (A >> (6'd32 - 6'(sh)))};
        OP_SHR:  result = {{WIDTH{1'b0}}, A >> sh};
        OP_SHRA: result = {{WIDTH{1'b0}}, WIDTH'($signed(A) >>> sh)};
        OP_SHL:  result = {{WIDTH{1'b0}}, A << sh};
`ifdef DATAPATH_MULDIV_EN
        OP_MUL:  result = prod;
        OP_DIV:  result = {rem, quot};
`endif
        OP_NEG:  result = {{WIDTH{1'b0}}, WIDTH'(0) - B};
        OP_NOT:  result = {{WIDTH{1'b0}}, ~B};
        default: result = '0;
      endcase
    end
  end

endmodule

// File: rtl/cpu_datapath.sv
// Single-bus 32-bit CPU datapath: register set, encoder-driven bus mux, ALU into 64-bit Z.
// Optional MUL/DIV in the ALU is enabled by defining DATAPATH_MULDIV_EN.
module cpu_datapath
  import datapath_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              R0out,
  input  logic              R1out,
  input  logic              R2out,
  input  logic              R3out,
  input  logic              R4out,
  input  logic              R5out,
  input  logic              R6out,
  input  logic              R7out,
  input  logic              R8out,
  input  logic              R9out,
  input  logic              R10out,
  input  logic              R11out,
  input  logic              R12out,
  input  logic              R13out,
  input  logic              R14out,
  input  logic              R15out,
  input  logic              HIout,
  input  logic              LOout,
  input  logic              ZHighout,
  input  logic              Zlowout,
  input  logic              PCout,
  input  logic              MDRout,
  input  logic              InPortout,
  input  logic              Cout,
  input  logic              R3in,
  input  logic              R4in,
  input  logic              R7in,
  input  logic              PCin,
  input  logic              IRin,
  input  logic              Yin,
  input  logic              Zin,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              IncPC,
  input  logic              AND,
  input  logic [WIDTH-1:0]  Mdatain,
  input  logic [OPW-1:0]    operation,
  output logic [31:0]       encoder_input
);

  logic [WIDTH-1:0] bus_data;
  logic [WIDTH-1:0] R3_data_out;
  logic [WIDTH-1:0] R4_data_out;
  logic [WIDTH-1:0] R7_data_out;
  logic [WIDTH-1:0] IR_data_out;
  logic [WIDTH-1:0] Y_data_out;
  logic [WIDTH-1:0] PC_data_out;
  logic [WIDTH-1:0] MAR_data_out;
  logic [WIDTH-1:0] ZLow_data_out;
  logic [WIDTH-1:0] ZHigh_data_out;
  logic [WIDTH-1:0] mdr_data_out;
  logic [WIDTH-1:0] c_sign_ext;
  logic [ZW-1:0]    c_data_out;
  logic [SELW-1:0]  enc_sel;
  logic             unused;

  assign encoder_input = {8'b0, Cout, InPortout, MDRout, PCout, Zlowout, ZHighout, LOout, HIout,
                          R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                          R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

  assign c_sign_ext = sign_ext_c(IR_data_out[CIMMW-1:0]);

  // MAR has no reader inside this block; upper IR bits and AND are decoded elsewhere.
  assign unused = ^{IR_data_out[WIDTH-1:CIMMW], MAR_data_out, AND};

  bus_encoder bus_encoder (
    .encoderInput  (encoder_input),
    .encoderOutput (enc_sel)
  );

  // Sources without load ports (R0-R2, R5, R6, R8-R15, HI, LO, InPort) read as zero.
  always_comb begin
    bus_data = '0;
    if (|encoder_input) begin
      case (enc_sel)
        ENC_R3:    bus_data = R3_data_out;
        ENC_R4:    bus_data = R4_data_out;
        ENC_R7:    bus_data = R7_data_out;
        ENC_ZHIGH: bus_data = ZHigh_data_out;
        ENC_ZLOW:  bus_data = ZLow_data_out;
        ENC_PC:    bus_data = PC_data_out;
        ENC_MDR:   bus_data = mdr_data_out;
        ENC_C:     bus_data = c_sign_ext;
        default:   bus_data = '0;
      endcase
    end
  end

  mdr_unit mdr_unit (
    .clk     (Clock),
    .reset   (Reset),
    .MDRin   (MDRin),
    .Read    (Read),
    .bus     (bus_data),
    .Mdatain (Mdatain),
    .MDRout  (mdr_data_out)
  );

  alu alu (
    .A         (Y_data_out),
    .B         (bus_data),
    .operation (operation),
    .IncPC     (IncPC),
    .result    (c_data_out)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      R3_data_out    <= '0;
      R4_data_out    <= '0;
      R7_data_out    <= '0;
      PC_data_out    <= '0;
      IR_data_out    <= '0;
      Y_data_out     <= '0;
      MAR_data_out   <= '0;
      ZLow_data_out  <= '0;
      ZHigh_data_out <= '0;
    end else begin
      if (R3in)  R3_data_out  <= bus_data;
      if (R4in)  R4_data_out  <= bus_data;
      if (R7in)  R7_data_out  <= bus_data;
      if (PCin)  PC_data_out  <= bus_data;
      if (IRin)  IR_data_out  <= bus_data;
      if (Yin)   Y_data_out   <= bus_data;
      if (MARin) MAR_data_out <= bus_data;
      if (Zin) begin
        ZHigh_data_out <= c_data_out[ZW-1:WIDTH];
        ZLow_data_out  <= c_data_out[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_cpu_datapath.sv
// Scoreboard bench for cpu_datapath: stimulus queues expectations, a negedge monitor checks them.
module tb_cpu_datapath;

  localparam int S_R3  = 0;
  localparam int S_R4  = 1;
  localparam int S_R7  = 2;
  localparam int S_PC  = 3;
  localparam int S_IR  = 4;
  localparam int S_Y   = 5;
  localparam int S_ZL  = 6;
  localparam int S_ZH  = 7;
  localparam int S_MAR = 8;
  localparam int S_MDR = 9;
  localparam int S_BUS = 10;
  localparam int S_ENC = 11;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] rout;
  logic        HIout, LOout, ZHighout, Zlowout, PCout, MDRout, InPortout, Cout;
  logic        R3in, R4in, R7in, PCin, IRin, Yin, Zin, MARin, MDRin;
  logic        Read, IncPC, and_strobe;
  logic [31:0] Mdatain;
  logic [4:0]  operation;
  logic [31:0] encoder_input;

  string       name_q[$];
  int          sig_q[$];
  logic [63:0] exp_q[$];
  int          tests = 0;
  int          failures = 0;

  always #5 Clock = ~Clock;

  cpu_datapath dut (
    .Clock(Clock), .Reset(Reset),
    .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
    .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
    .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .HIout(HIout), .LOout(LOout), .ZHighout(ZHighout), .Zlowout(Zlowout),
    .PCout(PCout), .MDRout(MDRout), .InPortout(InPortout), .Cout(Cout),
    .R3in(R3in), .R4in(R4in), .R7in(R7in), .PCin(PCin), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .MARin(MARin), .MDRin(MDRin),
    .Read(Read), .IncPC(IncPC), .AND(and_strobe),
    .Mdatain(Mdatain), .operation(operation), .encoder_input(encoder_input)
  );

  function automatic logic [63:0] probe(input int s);
    case (s)
      S_R3:    return 64'(dut.R3_data_out);
      S_R4:    return 64'(dut.R4_data_out);
      S_R7:    return 64'(dut.R7_data_out);
      S_PC:    return 64'(dut.PC_data_out);
      S_IR:    return 64'(dut.IR_data_out);
      S_Y:     return 64'(dut.Y_data_out);
      S_ZL:    return 64'(dut.ZLow_data_out);
      S_ZH:    return 64'(dut.ZHigh_data_out);
      S_MAR:   return 64'(dut.MAR_data_out);
      S_MDR:   return 64'(dut.mdr_unit.MDRout);
      S_BUS:   return 64'(dut.bus_data);
      default: return 64'(encoder_input);
    endcase
  endfunction

  task automatic expect_v(input string n, input int s, input logic [63:0] e);
    name_q.push_back(n);
    sig_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // Monitor: drain and compare everything queued, sampled on the falling edge.
  initial begin
    string       n;
    int          s;
    logic [63:0] e;
    logic [63:0] act;
    forever begin
      @(negedge Clock);
      while (sig_q.size() > 0) begin
        n = name_q.pop_front();
        s = sig_q.pop_front();
        e = exp_q.pop_front();
        act = probe(s);
        tests++;
        if (act !== e) begin
          failures++;
          $display("FAIL %s: got %h expected %h", n, act, e);
        end
      end
    end
  end

  task automatic idle();
    rout = '0;
    {HIout, LOout, ZHighout, Zlowout, PCout, MDRout, InPortout, Cout} = '0;
    {R3in, R4in, R7in, PCin, IRin, Yin, Zin, MARin, MDRin} = '0;
    {Read, IncPC, and_strobe} = '0;
    Mdatain = '0;
    operation = '0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    idle();
    Mdatain = v;
    Read = 1'b1;
    MDRin = 1'b1;
    tick();
    expect_v("mdr_load", S_MDR, 64'(v));
    idle();
  endtask

  // Y op MDR (or an undriven bus) into Z.
  task automatic alu_op(input string n, input logic [4:0] op, input logic use_mdr,
                        input logic inc, input logic [63:0] e);
    idle();
    MDRout = use_mdr;
    operation = op;
    IncPC = inc;
    Zin = 1'b1;
    and_strobe = 1'b1;
    tick();
    expect_v({n, "_zlow"}, S_ZL, 64'(e[31:0]));
    expect_v({n, "_zhigh"}, S_ZH, 64'(e[63:32]));
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int s = S_R3; s <= S_ENC; s++) expect_v("reset", s, 64'h0);

    // Register loads through MDR
    load_mdr(32'h22); MDRout = 1'b1; R3in = 1'b1;
    expect_v("bus_mdr", S_BUS, 64'h22);
    tick(); expect_v("r3_load", S_R3, 64'h22);
    load_mdr(32'h24); MDRout = 1'b1; R7in = 1'b1;
    tick(); expect_v("r7_load", S_R7, 64'h24);
    load_mdr(32'h28); MDRout = 1'b1; R4in = 1'b1;
    tick(); expect_v("r4_load", S_R4, 64'h28);

    // Bus priority: lowest set strobe wins, R0 reads zero
    idle(); rout[3] = 1'b1; rout[7] = 1'b1;
    expect_v("prio_r3_r7", S_BUS, 64'h22);
    tick(); idle(); rout[4] = 1'b1; Cout = 1'b1;
    expect_v("prio_r4_c", S_BUS, 64'h28);
    expect_v("enc_r4_c", S_ENC, 64'h0080_0010);
    tick(); idle(); rout[0] = 1'b1;
    expect_v("bus_r0", S_BUS, 64'h0);
    expect_v("enc_r0", S_ENC, 64'h1);
    tick(); idle();
    expect_v("bus_none", S_BUS, 64'h0);

    // Fetch step: PC to MAR, Z = PC + 1, then PC <= Z
    idle(); PCout = 1'b1; MDRout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
    expect_v("fetch_bus", S_BUS, 64'h0);
    expect_v("fetch_enc", S_ENC, 64'h0030_0000);
    tick();
    expect_v("fetch_mar", S_MAR, 64'h0);
    expect_v("fetch_zlow", S_ZL, 64'h1);
    expect_v("fetch_zhigh", S_ZH, 64'h0);
    idle(); Zlowout = 1'b1; PCin = 1'b1;
    expect_v("zlow_bus", S_BUS, 64'h1);
    tick(); expect_v("pc_inc", S_PC, 64'h1);
    idle(); PCout = 1'b1; MARin = 1'b1;
    tick(); expect_v("mar_pc", S_MAR, 64'h1);

    // IR load and sign-extended C field
    load_mdr(32'h2A2B_8000); MDRout = 1'b1; IRin = 1'b1;
    tick(); expect_v("ir_load", S_IR, 64'h2A2B_8000);
    idle(); Cout = 1'b1;
    expect_v("c_pos", S_BUS, 64'h0003_8000);
    tick();
    load_mdr(32'h0004_0001); MDRout = 1'b1; IRin = 1'b1;
    tick(); idle(); Cout = 1'b1;
    expect_v("c_neg", S_BUS, 64'hFFFC_0001);
    tick();

    // SHR: R4 <= R3 >> (R7 & 31)
    idle(); rout[3] = 1'b1; Yin = 1'b1;
    tick(); expect_v("y_r3", S_Y, 64'h22);
    idle(); rout[7] = 1'b1; operation = 5'b01001; Zin = 1'b1;
    tick();
    expect_v("shr_zlow", S_ZL, 64'h2);
    expect_v("shr_zhigh", S_ZH, 64'h0);
    idle(); Zlowout = 1'b1; R4in = 1'b1;
    tick(); expect_v("r4_from_z", S_R4, 64'h2);

    // ALU sweep with Y = -2, bus = 3
    load_mdr(32'hFFFF_FFFE); MDRout = 1'b1; Yin = 1'b1;
    tick(); expect_v("y_neg2", S_Y, 64'hFFFF_FFFE);
    load_mdr(32'h3);
`ifdef DATAPATH_MULDIV_EN
    alu_op("mul", 5'b01111, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA);
`else
    alu_op("mul", 5'b01111, 1'b1, 1'b0, 64'h0);
`endif
    alu_op("add_wrap", 5'b00011, 1'b1, 1'b0, 64'h1);
    alu_op("sub",      5'b00100, 1'b1, 1'b0, 64'hFFFF_FFFB);
    alu_op("and",      5'b00101, 1'b1, 1'b0, 64'h2);
    alu_op("or",       5'b00110, 1'b1, 1'b0, 64'hFFFF_FFFF);
    alu_op("ror",      5'b00111, 1'b1, 1'b0, 64'hDFFF_FFFF);
    alu_op("rol",      5'b01000, 1'b1, 1'b0, 64'hFFFF_FFF7);
    alu_op("shr",      5'b01001, 1'b1, 1'b0, 64'h1FFF_FFFF);
    alu_op("shra",     5'b01010, 1'b1, 1'b0, 64'hFFFF_FFFF);
    alu_op("shl",      5'b01011, 1'b1, 1'b0, 64'hFFFF_FFF0);
    alu_op("neg",      5'b10001, 1'b1, 1'b0, 64'hFFFF_FFFD);
    alu_op("not",      5'b10010, 1'b1, 1'b0, 64'hFFFF_FFFC);
    alu_op("op_bad0",  5'b00000, 1'b1, 1'b0, 64'h0);
    alu_op("incpc",    5'b00011, 1'b1, 1'b1, 64'h4);
    alu_op("op_bad31", 5'b11111, 1'b1, 1'b0, 64'h0);

    // DIV with positive operands, then divide by zero
    load_mdr(32'd100); MDRout = 1'b1; Yin = 1'b1;
    tick(); expect_v("y_100", S_Y, 64'd100);
    load_mdr(32'd7);
`ifdef DATAPATH_MULDIV_EN
    alu_op("div", 5'b10000, 1'b1, 1'b0, 64'h0000_0002_0000_000E);
`else
    alu_op("div", 5'b10000, 1'b1, 1'b0, 64'h0);
`endif
    alu_op("not_pre", 5'b10010, 1'b1, 1'b0, 64'hFFFF_FFF8);
    alu_op("div0", 5'b10000, 1'b0, 1'b0, 64'h0);

    repeat (2) @(negedge Clock);
    #1;
    tests++;
    if (sig_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sig_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
